// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared register-file widths and writeback FSM states
package rf_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: two writeback requesters plus the register-file write port
interface rf_wb_arbiter_if;
  import rf_ctrl_pkg::*;
  logic a_valid, a_ready, b_valid, b_ready, rf_write, busy;
  logic [REG_ADDR_W-1:0] a_wn, b_wn, rf_wn;
  logic [DATA_W-1:0] a_wd, b_wd, rf_wd;
  modport master (
    output a_valid, a_wn, a_wd, b_valid, b_wn, b_wd,
    input  a_ready, b_ready, rf_write, rf_wn, rf_wd, busy
  );
  modport slave (
    input  a_valid, a_wn, a_wd, b_valid, b_wn, b_wd,
    output a_ready, b_ready, rf_write, rf_wn, rf_wd, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way one-hot grant, round-robin (RR_EN=1) or fixed priority with req[0] highest
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_b;
  always_comb gnt = !en ? 2'b00 : req == 2'b11 ? (RR_EN && !last_b ? 2'b10 : 2'b01) : req;
  // a grant is only ever issued to a valid requester, so any grant is a completed transfer
  always_ff @(posedge clk)
    if (!rst_n) last_b <= 1'b1;
    else if (|gnt) last_b <= gnt[1];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU (A) and load (B) writebacks onto one registered RF write port
// RF_INIT_EN adds a post-reset sweep writing zero to x1..x31 while busy is high.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  rf_wb_arbiter_if.slave bus
);
  state_t state;
  logic [1:0] gnt;
  logic sweep;
  logic [REG_ADDR_W-1:0] sweep_wn, wn;
  logic [DATA_W-1:0] wd;
  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk,
    .rst_n,
    .en(rst_n && state == RUN),
    .req({bus.b_valid, bus.a_valid}),
    .gnt
  );
  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];
  assign wn = gnt[1] ? bus.b_wn : bus.a_wn;
  assign wd = gnt[1] ? bus.b_wd : bus.a_wd;
`ifdef RF_INIT_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= INIT;
      sweep_wn <= REG_ADDR_W'(1);
    end else if (state == INIT) begin
      sweep_wn <= sweep_wn + 1'b1;
      if (sweep_wn == REG_ADDR_W'(NUM_REGS - 1)) state <= RUN;
    end
  assign bus.busy = state == INIT;
`else
  assign state = RUN;
  assign sweep_wn = '0;
  assign bus.busy = 1'b0;
`endif
  assign sweep = state == INIT;
  // x0 is hardwired zero: the handshake completes but no write is issued
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.rf_write <= 1'b0;
      bus.rf_wn <= '0;
      bus.rf_wd <= '0;
    end else begin
      bus.rf_write <= sweep || (|gnt && wn != '0);
      bus.rf_wn <= sweep ? sweep_wn : wn;
      bus.rf_wd <= sweep ? '0 : wd;
    end
endmodule
